// File: rtl/bram_stream_out_if.sv
// bram_stream_out_if: BRAM read port plus AXI-Stream master bundle for bram_stream_out
interface bram_stream_out_if #(parameter int ADDR_WIDTH = 12);
  logic [ADDR_WIDTH-1:0] rd_addra;
  logic rd_en;
  logic [7:0] rd_douta;
  logic tx_valid;
  logic tx_ready;
  logic [31:0] tx_data;
  logic [3:0] tx_keep;
  logic tx_last;
  modport master (output rd_addra, rd_en, tx_valid, tx_data, tx_keep, tx_last, input rd_douta, tx_ready);
  modport slave (input rd_addra, rd_en, tx_valid, tx_data, tx_keep, tx_last, output rd_douta, tx_ready);
endinterface

// File: rtl/bram_stream_out.sv
// bram_stream_out: streams a BRAM byte buffer as little-endian 32-bit AXIS words; STREAM_OUT_CHECKSUM_EN adds a 16-bit sum trailer beat
module bram_stream_out #(parameter int ADDR_WIDTH = 12) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic [12:0] byte_count,
  output logic busy,
  output logic done,
  bram_stream_out_if.master bus
);
  typedef enum logic [1:0] {IDLE, FILL, SEND, FINISH} state_t;
  state_t state_q;
  logic [12:0] rem_q, len_d, left_d;
  logic [2:0] k_q, cyc_q, k_start_d, k_next_d;
  logic [1:0] lane_d;
  logic [ADDR_WIDTH-1:0] rd_addra_q;
  logic rd_en_q, tx_valid_q, tx_last_q;
  logic [31:0] tx_data_q;
  logic [3:0] tx_keep_q;
`ifdef STREAM_OUT_CHECKSUM_EN
  logic [15:0] sum_q;
  logic trl_q;
`endif
  assign busy = state_q != IDLE;
  assign done = state_q == FINISH;
  assign bus.rd_addra = rd_addra_q;
  assign bus.rd_en = rd_en_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.tx_data = tx_data_q;
  assign bus.tx_keep = tx_keep_q;
  assign bus.tx_last = tx_last_q;
  // clamped request length, bytes left after the current word, chunk sizes and capture lane
  always_comb begin
    len_d = byte_count > 13'd4096 ? 13'd4096 : byte_count;
    left_d = rem_q - {10'd0, k_q};
    k_start_d = len_d > 13'd3 ? 3'd4 : len_d[2:0];
    k_next_d = left_d > 13'd3 ? 3'd4 : left_d[2:0];
    lane_d = cyc_q[1:0] - 2'd1;
  end
  // transfer FSM: read k bytes into the word register, then hold it on AXIS until accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q <= '0;
      k_q <= '0;
      cyc_q <= '0;
      rd_addra_q <= '0;
      rd_en_q <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_last_q <= 1'b0;
      tx_data_q <= '0;
      tx_keep_q <= '0;
`ifdef STREAM_OUT_CHECKSUM_EN
      sum_q <= '0;
      trl_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (start) begin
          rem_q <= len_d;
          k_q <= k_start_d;
          cyc_q <= '0;
          rd_addra_q <= '0;
          tx_data_q <= '0;
          rd_en_q <= len_d != 13'd0;
          state_q <= len_d == 13'd0 ? FINISH : FILL;
`ifdef STREAM_OUT_CHECKSUM_EN
          sum_q <= '0;
          trl_q <= 1'b0;
`endif
        end
        FILL: begin
          cyc_q <= cyc_q + 3'd1;
          rd_en_q <= cyc_q + 3'd1 < k_q;
          if (rd_en_q) rd_addra_q <= rd_addra_q + 1'b1;
          if (cyc_q != 3'd0) begin
            tx_data_q[{lane_d, 3'b000} +: 8] <= bus.rd_douta;
`ifdef STREAM_OUT_CHECKSUM_EN
            sum_q <= sum_q + {8'd0, bus.rd_douta};
`endif
          end
          if (cyc_q == k_q) begin
            state_q <= SEND;
            tx_valid_q <= 1'b1;
            tx_keep_q <= 4'b1111 >> (3'd4 - k_q);
`ifdef STREAM_OUT_CHECKSUM_EN
            tx_last_q <= 1'b0;
`else
            tx_last_q <= left_d == 13'd0;
`endif
          end
        end
        SEND: if (bus.tx_ready) begin
          tx_valid_q <= 1'b0;
          tx_last_q <= 1'b0;
          tx_keep_q <= '0;
          tx_data_q <= '0;
          rem_q <= left_d;
          if (left_d != 13'd0) begin
            state_q <= FILL;
            k_q <= k_next_d;
            cyc_q <= '0;
            rd_en_q <= 1'b1;
          end
`ifdef STREAM_OUT_CHECKSUM_EN
          else if (!trl_q) begin
            trl_q <= 1'b1;
            k_q <= '0;
            tx_valid_q <= 1'b1;
            tx_data_q <= {16'd0, sum_q};
            tx_keep_q <= 4'b1111;
            tx_last_q <= 1'b1;
          end
`endif
          else state_q <= FINISH;
        end
        FINISH: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/bram_stream_out.md
BRAM_STREAM_OUT -- requirements
Module: bram_stream_out

Interface
REQ-001 SHALL have parameter: ADDR_WIDTH, 12, BRAM byte-address width (max 4096 bytes).
REQ-002 SHALL have port: clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  single-cycle request to stream a buffer; honoured only in IDLE.
REQ-005 SHALL have port: byte_count  input  13  number of bytes to send, sampled with start.
REQ-006 SHALL have port: busy  output  1  high in every state except IDLE.
REQ-007 SHALL have port: done  output  1  one-cycle pulse when the transfer completes.
REQ-008 SHALL have port: rd_addra  output  ADDR_WIDTH  BRAM read byte address.
REQ-009 SHALL have port: rd_en  output  1  BRAM read enable.
REQ-010 SHALL have port: rd_douta  input  8  BRAM read data, valid exactly one cycle after rd_en.
REQ-011 SHALL have port: tx_valid  output  1  AXIS master TVALID.
REQ-012 SHALL have port: tx_ready  input  1  AXIS master TREADY.
REQ-013 SHALL have port: tx_data  output  32  AXIS master TDATA.
REQ-014 SHALL have port: tx_keep  output  4  AXIS master TKEEP.
REQ-015 SHALL have port: tx_last  output  1  AXIS master TLAST.

Function
REQ-016 SHALL implement FSM states IDLE, FILL, SEND, FINISH.
REQ-017 SHALL, in IDLE with start=1, latch byte_count (clamped to 4096), clear the address counter and enter FILL; if byte_count=0, SHALL instead enter FINISH directly with no BRAM reads and no AXIS beats.
REQ-018 SHALL, in FILL, assert rd_en on consecutive cycles for k = min(4, remaining) bytes at ascending addresses starting at 0, then enter SEND on the cycle after the last read's data is captured (k+1 cycles in FILL).
REQ-019 SHALL pack bytes little-endian: the lowest-address byte goes to tx_data[7:0], the next to [15:8], and so on.
REQ-020 SHALL drive unused lanes of a partial word to 0 and set tx_keep to the contiguous low-lane mask (k=1: 4'b0001, 2: 4'b0011, 3: 4'b0111, 4: 4'b1111).
REQ-021 SHALL, in SEND, assert tx_valid and hold tx_data, tx_keep and tx_last stable until the cycle in which tx_valid and tx_ready are both 1.
REQ-022 SHALL assert tx_last only on the final beat of the transfer.
REQ-023 SHALL, on handshake, decrement remaining by k and go to FILL if remaining>0; otherwise SHALL go to FINISH.
REQ-024 SHALL, in FINISH, assert done for exactly one cycle, then return to IDLE.
REQ-025 SHALL ignore start while busy=1.
REQ-026 SHALL deassert rd_en outside FILL and tx_valid outside SEND.
REQ-027 SHALL tolerate tx_ready held high permanently, giving a throughput of one word per 6 cycles for full words.
REQ-028 SHALL accept tx_ready asserted before tx_valid without any effect on transfer sequencing.

Reset
REQ-029 SHALL, on reset=1 at a clock edge, enter IDLE from any state, aborting any transfer without emitting further beats.
REQ-030 SHALL set these reset values: busy=0, done=0, rd_en=0, rd_addra=0, tx_valid=0, tx_last=0, tx_keep=0, tx_data=0, and internal counters 0.

Configuration
REQ-031 SHALL, with macro STREAM_OUT_CHECKSUM_EN defined, after the last data beat send one extra trailer beat: tx_data = {16'd0, 16-bit wrap-around sum of all bytes sent}, tx_keep=4'b1111, tx_last=1; in this mode the last data beat SHALL have tx_last=0.
REQ-032 SHALL, with STREAM_OUT_CHECKSUM_EN undefined, send no trailer and contain no checksum logic.
REQ-033 SHALL, with the macro defined and byte_count=0, still emit no beats.

Verification
REQ-034 SHALL verify: BRAM[0..7]=01..08, byte_count=8, tx_ready=1 -> beats 32'h04030201 keep F last 0, then 32'h08070605 keep F last 1; done pulses once.
REQ-035 SHALL verify: byte_count=5, BRAM[4]=AA -> second beat 32'h000000AA, keep 4'b0001, last 1.
REQ-036 SHALL verify: tx_ready held low for 10 cycles during SEND -> tx_valid and tx_data stable throughout; no address advance.
REQ-037 SHALL verify: byte_count=0 -> no rd_en, no tx_valid; done one cycle after start; start during busy ignored.
REQ-038 SHALL verify: reset asserted mid-SEND -> next cycle tx_valid=0, busy=0; a new start with byte_count=4 streams correctly from address 0.
REQ-039 SHALL verify: with STREAM_OUT_CHECKSUM_EN, byte_count=4 of FF -> data beat last 0, trailer 32'h000003FC last 1.
